// File: rtl/ref_clk_pkg.sv
// Shared state encoding, limits and waveform helper for the reference-clock pattern generator.
// Definitions only: no timing, no flow control.
package ref_clk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int unsigned DIV_MIN = 2;

  // Helper operand width; callers zero-extend their DIV_W+1 bit indices into it.
  localparam int unsigned HB_W = 16;
  typedef logic [HB_W-1:0] hb_val_t;

  // Half-cycle p of a div-long period is high for the first ceil(div/2) slots.
  function automatic logic hi_bit(input hb_val_t p, input hb_val_t div);
    return p < ((div + hb_val_t'(1)) >> 1);
  endfunction

endpackage

// File: rtl/ref_clk_phase_acc.sv
// Half-cycle phase accumulator: two slot indices per clk, +2 mod div advance, boundary-slot flags.
// Indices are combinational from the registered position; restart re-bases the current cycle to index 0.
module ref_clk_phase_acc
  import ref_clk_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  input  logic             adv,
  output logic [DIV_W:0]   idx1,
  output logic [DIV_W:0]   idx2,
  output logic             bnd_d1,
  output logic             bnd_d2
);

  logic [DIV_W:0] pos_q;
  logic [DIV_W:0] pos_d;
  logic [DIV_W:0] div_x;
  logic [DIV_W:0] base;
  logic [DIV_W:0] inc1;
  logic [DIV_W:0] inc2;

  always_comb begin
    div_x  = {1'b0, div};
    base   = restart ? '0 : pos_q;
    inc1   = base + (DIV_W + 1)'(1);
    inc2   = base + (DIV_W + 1)'(2);
    idx1   = base;
    idx2   = (inc1 >= div_x) ? '0 : inc1;
    bnd_d1 = (base == '0);
    bnd_d2 = (inc1 == div_x);
    pos_d  = pos_q;
    // pos < div and div >= 2, so a single subtraction always lands back in range.
    if (adv) begin
      pos_d = (inc2 >= div_x) ? (inc2 - div_x) : inc2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/ref_clk_pattern_gen.sv
// ODDR D1/D2 pattern generator for the ADC reference clock; optional period counter under REF_CLK_PERIOD_CNT_EN.
// Registered outputs, first high bit 2 cycles after enable; cfg_ready only in IDLE so config is held off, never lost.
module ref_clk_pattern_gen
  import ref_clk_pkg::*;
#(
  parameter int unsigned      DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             enable,
  input  logic             sync_req,
  output logic             sync_ack,
  output logic             d1,
  output logic             d2,
  output logic             running
`ifdef REF_CLK_PERIOD_CNT_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             d1_q;
  logic             d1_d;
  logic             d2_q;
  logic             d2_d;
  logic             sync_ack_q;
  logic             sync_ack_d;
  logic             cfg_err_q;
  logic             cfg_err_d;

  logic             restart;
  logic             adv;
  logic [DIV_W:0]   idx1;
  logic [DIV_W:0]   idx2;
  logic             bnd_d1;
  logic             bnd_d2;
  logic             hi1;
  logic             hi2;

  // ARMED re-bases to index 0 so the first RUN cycle already shows d1=1.
  assign restart = (state_q == ARMED) || ((state_q == RUN) && sync_req);
  assign adv     = (state_q != IDLE);

  ref_clk_phase_acc #(
    .DIV_W (DIV_W)
  ) u_phase_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div_q),
    .restart (restart),
    .adv     (adv),
    .idx1    (idx1),
    .idx2    (idx2),
    .bnd_d1  (bnd_d1),
    .bnd_d2  (bnd_d2)
  );

  assign hi1 = hi_bit(hb_val_t'(idx1), hb_val_t'(div_q));
  assign hi2 = hi_bit(hb_val_t'(idx2), hb_val_t'(div_q));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    d1_d       = 1'b0;
    d2_d       = 1'b0;
    sync_ack_d = 1'b0;
    cfg_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_div < DIV_MIN_V) begin
            cfg_err_d = 1'b1;
          end else begin
            div_d = cfg_div;
          end
        end
        if (enable) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (enable) begin
          d1_d    = hi1;
          d2_d    = hi2;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        d1_d       = hi1;
        d2_d       = hi2;
        sync_ack_d = sync_req;
        if (!enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Stop only where a new period would begin, so the last high pulse is never truncated.
        if (enable) begin
          d1_d    = hi1;
          d2_d    = hi2;
          state_d = RUN;
        end else if (bnd_d1) begin
          state_d = IDLE;
        end else if (bnd_d2) begin
          d1_d    = hi1;
          state_d = IDLE;
        end else begin
          d1_d = hi1;
          d2_d = hi2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= DIV_RST;
      d1_q       <= 1'b0;
      d2_q       <= 1'b0;
      sync_ack_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      sync_ack_q <= sync_ack_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign d1        = d1_q;
  assign d2        = d2_q;
  assign sync_ack  = sync_ack_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_ready = (state_q == IDLE);
  assign running   = (state_q == RUN) || (state_q == DRAIN);

`ifdef REF_CLK_PERIOD_CNT_EN
  logic [DIV_W:0] div_m1;
  logic           last_slot;
  logic           period_end;
  logic [31:0]    period_cnt_q;
  logic [31:0]    period_cnt_d;

  // A period counts once its final half-cycle is actually emitted on a pin slot.
  always_comb begin
    div_m1       = {1'b0, div_q} - (DIV_W + 1)'(1);
    last_slot    = (idx1 == div_m1) || (idx2 == div_m1);
    period_end   = last_slot && (state_q != IDLE)
                   && !((state_q == ARMED) && !enable)
                   && !((state_q == DRAIN) && !enable && bnd_d1);
    period_cnt_d = period_cnt_q;
    case (state_q)
      ARMED:      period_cnt_d = period_end ? 32'd1 : 32'd0;
      RUN, DRAIN: if (period_end) period_cnt_d = period_cnt_q + 32'd1;
      default:    period_cnt_d = period_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_ref_clk_pattern_gen.sv
// Directed-vector bench for ref_clk_pattern_gen; pairs below are written as {d1,d2}.
// Inputs change 1 ns after the rising edge and outputs are sampled at the same point.
module tb_ref_clk_pattern_gen;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic             enable;
  logic             sync_req;
  logic             sync_ack;
  logic             d1;
  logic             d2;
  logic             running;
`ifdef REF_CLK_PERIOD_CNT_EN
  logic [31:0]      period_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ref_clk_pattern_gen #(
    .DIV_W   (DIV_W),
    .DIV_RST (8'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .enable    (enable),
    .sync_req  (sync_req),
    .sync_ack  (sync_ack),
    .d1        (d1),
    .d2        (d2),
    .running   (running)
`ifdef REF_CLK_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_div(input logic [DIV_W-1:0] v);
    cfg_div   = v;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic e1;
    logic e2;
    rst_n     = 1'b0;
    cfg_div   = '0;
    cfg_valid = 1'b0;
    enable    = 1'b0;
    sync_req  = 1'b0;
    step();
    step();
    check("rst_pair",        32'({d1, d2}), 32'h0);
    check("rst_cfg_ready",   32'(cfg_ready), 32'h1);
    check("rst_err_ack_run", 32'({cfg_err, sync_ack, running}), 32'h0);
    rst_n = 1'b1;

    // div=2 passthrough: 1/0 from the second cycle after enable
    enable = 1'b1;
    step();
    check("t1_armed", 32'({d1, d2, running, cfg_ready}), 32'h0);
    step();
    check("t1_first_pair", 32'({d1, d2}), 32'h2);
    check("t1_running",    32'(running), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_run_pair", 32'({d1, d2}), 32'h2);
    end
    enable = 1'b0;
    step();
    check("t1_drain", 32'({d1, d2, running}), 32'h5);
    step();
    check("t1_idle", 32'({d1, d2, running, cfg_ready}), 32'h1);

    // illegal divide is rejected and the old value stays in force
    cfg_div   = 8'd1;
    cfg_valid = 1'b1;
    step();
    check("t5_err_pulse", 32'(cfg_err), 32'h1);
    cfg_valid = 1'b0;
    step();
    check("t5_err_clear", 32'(cfg_err), 32'h0);
    sync_req = 1'b1;
    step();
    check("idle_sync_ignored", 32'(sync_ack), 32'h0);
    sync_req = 1'b0;
    enable   = 1'b1;
    step();
    step();
    check("t5_div_kept", 32'({d1, d2}), 32'h2);
    enable = 1'b0;
    step();
    step();
    check("t5_back_idle", 32'({d1, d2, cfg_ready}), 32'h1);

    // div=5 loaded in the same cycle as enable; bitstream 11100 repeating
    cfg_div   = 8'd5;
    cfg_valid = 1'b1;
    enable    = 1'b1;
    step();
    check("t2_accept", 32'({cfg_ready, cfg_err}), 32'h0);
    cfg_div = 8'd8;
    for (int c = 0; c <= 10; c++) begin
      step();
      e1 = ((2 * c) % 5) < 3;
      e2 = ((2 * c + 1) % 5) < 3;
      check("t2_div5_pair", 32'({d1, d2}), 32'({e1, e2}));
      if (c == 3) check("t5_cfg_held_off", 32'(cfg_ready), 32'h0);
    end
    enable = 1'b0;
    step();
    check("t2_drain_last", 32'({d1, d2, running}), 32'h5);
    // boundary sits in the d2 slot: d1 carries index 4 (low), d2 forced low
    step();
    check("t2_drain_d2_bnd", 32'({d1, d2, running, cfg_ready}), 32'h1);
    step();
    cfg_valid = 1'b0;

    // div=8 (the held-off request): stop mid-high, full high and low halves kept
    enable = 1'b1;
    step();
    step();
    check("t3_c0", 32'({d1, d2}), 32'h3);
    enable = 1'b0;
    step();
    check("t3_c1_high", 32'({d1, d2, running}), 32'h7);
    step();
    check("t3_c2_low", 32'({d1, d2, running}), 32'h1);
    step();
    check("t3_c3_low", 32'({d1, d2, running}), 32'h1);
    step();
    check("t3_stopped", 32'({d1, d2, running, cfg_ready}), 32'h1);

    // div=6 sync: request while the accumulator holds index 4
    load_div(8'd6);
    enable = 1'b1;
    step();
    step();
    check("t4_c0", 32'({d1, d2}), 32'h3);
    step();
    check("t4_c1", 32'({d1, d2}), 32'h2);
    sync_req = 1'b1;
    step();
    check("t4_sync_pair", 32'({d1, d2, sync_ack}), 32'h7);
    sync_req = 1'b0;
    step();
    check("t4_after_sync", 32'({d1, d2, sync_ack}), 32'h4);
    step();
    check("t4_low", 32'({d1, d2}), 32'h0);
    step();
    check("t4_wrap", 32'({d1, d2}), 32'h3);
    // sync and enable fall together: sync takes this cycle, then drain
    sync_req = 1'b1;
    enable   = 1'b0;
    step();
    check("t4_sync_and_stop", 32'({d1, d2, sync_ack, running}), 32'hF);
    sync_req = 1'b0;
    step();
    check("t4_drain1", 32'({d1, d2, sync_ack, running}), 32'h9);
    step();
    check("t4_drain2", 32'({d1, d2, running}), 32'h1);
    step();
    check("t4_stopped", 32'({d1, d2, running}), 32'h0);

    // reset while running: outputs drop next cycle, divide returns to 2
    enable = 1'b1;
    step();
    step();
    step();
    check("t6_pre_reset", 32'({d1, d2}), 32'h2);
    rst_n = 1'b0;
    step();
    check("t6_reset_out", 32'({d1, d2, running, cfg_ready}), 32'h1);
    rst_n = 1'b1;
    step();
    step();
    check("t6_div_rst", 32'({d1, d2}), 32'h2);
    enable = 1'b0;
    step();
    step();

    // enable dropped while ARMED returns to IDLE without output
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    check("armed_abort", 32'({d1, d2, running, cfg_ready}), 32'h1);

    // re-enable during drain keeps the phase
    load_div(8'd8);
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    check("redrive_c2", 32'({d1, d2, running}), 32'h1);
    step();
    step();
    check("redrive_c4", 32'({d1, d2, running}), 32'h7);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("redrive_stopped", 32'({d1, d2, running}), 32'h0);

`ifdef REF_CLK_PERIOD_CNT_EN
    load_div(8'd4);
    enable = 1'b1;
    step();
    for (int i = 0; i < 40; i++) step();
    check("period_cnt_40", period_cnt, 32'd20);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("period_cnt_frozen", period_cnt, 32'd21);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
